// File: rtl/ripple_adder.sv
// ripple_adder: registered WIDTH-bit ripple-carry adder with carry-in/out; signed overflow flag under RIPPLE_ADDER_OVF_EN
module ripple_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             out_valid
`ifdef RIPPLE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;
    // one full adder per bit, carry rippling from bit 0 upward
    always_comb begin
        carry[0] = c;
        sum      = '0;
        for (int k = 0; k < WIDTH; k++) begin
            sum[k]     = a[k] ^ b[k] ^ carry[k];
            carry[k+1] = (a[k] & b[k]) | (a[k] & carry[k]) | (b[k] & carry[k]);
        end
    end
    // result register: loads on accepted operands, holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s  <= '0;
            co <= 1'b0;
        end else if (in_valid) begin
            s  <= sum;
            co <= carry[WIDTH];
        end
    end
    // out_valid marks the cycle after an accepted operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_valid <= 1'b0;
        else     out_valid <= in_valid;
    end
`ifdef RIPPLE_ADDER_OVF_EN
    // two's-complement overflow: like-signed operands yielding a result of the other sign
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           ovf <= 1'b0;
        else if (in_valid) ovf <= (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end
`endif
endmodule

// File: tb/tb_ripple_adder.sv
// tb_ripple_adder: randomized and directed check of ripple_adder against an arithmetic model
module tb_ripple_adder;
    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] s;
    logic         co;
    logic         out_valid;
`ifdef RIPPLE_ADDER_OVF_EN
    logic         ovf;
`endif

    int tests = 0;
    int fails = 0;

    int m_s = 0;
    int m_co = 0;
    int m_ov = 0;
    int m_ovf = 0;

    ripple_adder #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .b(b),
        .c(c),
        .in_valid(in_valid),
        .s(s),
        .co(co),
        .out_valid(out_valid)
`ifdef RIPPLE_ADDER_OVF_EN
        ,
        .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic int to_signed(int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    // reference: plain integer arithmetic on the accepted operands
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s   <= 0;
            m_co  <= 0;
            m_ov  <= 0;
            m_ovf <= 0;
        end else begin
            m_ov <= int'(in_valid);
            if (in_valid) begin
                m_s   <= (int'(a) + int'(b) + int'(c)) % M;
                m_co  <= (int'(a) + int'(b) + int'(c)) / M;
                m_ovf <= int'((to_signed(int'(a)) + to_signed(int'(b)) + int'(c) > M / 2 - 1) ||
                              (to_signed(int'(a)) + to_signed(int'(b)) + int'(c) < -(M / 2)));
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("cyc_s", int'(s), m_s);
        check("cyc_co", int'(co), m_co);
        check("cyc_valid", int'(out_valid), m_ov);
`ifdef RIPPLE_ADDER_OVF_EN
        check("cyc_ovf", int'(ovf), m_ovf);
`endif
    endtask

    task automatic lit(input string name, input int es, input int eco, input int eov);
        check({name, "_s"}, int'(s), es);
        check({name, "_co"}, int'(co), eco);
        check({name, "_valid"}, int'(out_valid), eov);
        check({name, "_model_s"}, m_s, es);
        check({name, "_model_co"}, m_co, eco);
    endtask

    task automatic apply(input int va, input int vb, input int vc, input int vv);
        a        = W'(va);
        b        = W'(vb);
        c        = vc[0];
        in_valid = vv[0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        lit("reset", 0, 0, 0);
        fork
            forever begin
                @(negedge clk);
                compare_all();
            end
        join_none
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        lit("release", 0, 0, 0);
        @(posedge clk);
        #1;
        apply(0, 0, 0, 1);
        lit("zero", 0, 0, 1);
        for (int i = 1; i <= 13; i += 2) begin
            apply(i, 1, 0, 1);
            lit("sweep", i + 1, 0, 1);
        end
        apply(1, 15, 0, 1);
        lit("wrap", 0, 1, 1);
        apply(1, 14, 0, 1);
        lit("nowrap", 15, 0, 1);
        apply(5, 15, 1, 1);
        lit("cin", 5, 1, 1);
        apply(15, 15, 1, 1);
        lit("max", 15, 1, 1);
        apply(7, 7, 0, 0);
        lit("hold1", 15, 1, 0);
        apply(3, 3, 1, 0);
        lit("hold2", 15, 1, 0);
        apply(4, 5, 0, 1);
        lit("pre_rst", 9, 0, 1);
        a        = 4'd2;
        b        = 4'd2;
        in_valid = 1'b1;
        rst      = 1'b1;
        #1;
        lit("async_rst", 0, 0, 0);
        @(posedge clk);
        #1;
        lit("in_rst", 0, 0, 0);
        rst = 1'b0;
        #1;
        lit("deassert", 0, 0, 0);
        apply(3, 3, 0, 0);
        lit("idle_after_rst", 0, 0, 0);
        apply(3, 3, 0, 1);
        lit("first_after_rst", 6, 0, 1);
`ifdef RIPPLE_ADDER_OVF_EN
        apply(7, 1, 0, 1);
        lit("ovf_pos", 8, 0, 1);
        check("ovf_pos_flag", int'(ovf), 1);
        apply(5, 15, 1, 1);
        check("ovf_mixed_flag", int'(ovf), 0);
`endif
        for (int i = 0; i < 400; i++)
            apply(int'($urandom_range(M - 1)), int'($urandom_range(M - 1)),
                  int'($urandom_range(1)), int'($urandom_range(3) != 0));
        apply(0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ripple_adder.md
RIPPLE_ADDER -- requirements
Module: ripple_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/sum width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port a  input  WIDTH  operand A, unsigned.
REQ-005 SHALL have port b  input  WIDTH  operand B, unsigned.
REQ-006 SHALL have port c  input  1  carry-in.
REQ-007 SHALL have port in_valid  input  1  operands valid this cycle.
REQ-008 SHALL have port s  output  WIDTH  registered sum.
REQ-009 SHALL have port co  output  1  registered carry-out.
REQ-010 SHALL have port out_valid  output  1  s/co updated by the previous accepted operation.
REQ-011 SHALL have port ovf  output  1  registered signed (two's-complement) overflow; present only with RIPPLE_ADDER_OVF_EN.

Function
REQ-012 SHALL compute {co,s} = a + b + c, full WIDTH+1-bit result, no truncation of carry.
REQ-013 SHALL implement the sum as a chain of WIDTH full-adder stages: stage i takes a[i], b[i], carry[i]; carry[0]=c; co=carry[WIDTH]; no carry-lookahead.
REQ-014 Each full-adder stage SHALL compute sum = a^b^cin, cout = (a&b)|(a&cin)|(b&cin).
REQ-015 On a rising clk edge with in_valid=1, s and co SHALL load the combinational result; latency exactly 1 cycle.
REQ-016 On a rising clk edge with in_valid=0, s, co (and ovf) SHALL hold their previous values.
REQ-017 out_valid SHALL equal in_valid registered by one clk cycle (1 on the cycle after an accepted operation, else 0).
REQ-018 Back-to-back in_valid=1 cycles SHALL each produce a result; throughput one operation per cycle, no stalls.
REQ-019 Wrap-around: when a+b+c >= 2^WIDTH, s SHALL be (a+b+c) mod 2^WIDTH and co SHALL be 1.
REQ-020 Maximum case a=b=all-ones, c=1 SHALL give s=all-ones, co=1.
REQ-021 Inputs SHALL have no effect on outputs between clock edges (no combinational path input to output).

Reset
REQ-022 While rst=1, s SHALL be 0, co 0, out_valid 0, ovf 0, immediately and independent of clk.
REQ-023 Operations in flight when rst asserts SHALL be discarded; first valid result after release appears one cycle after the first in_valid=1 edge with rst=0.
REQ-024 rst deassertion SHALL take effect on the next rising clk edge; no output changes at the deassertion instant.

Configuration
REQ-025 With macro RIPPLE_ADDER_OVF_EN defined, port ovf SHALL exist and register (a[W-1]==b[W-1]) && (s_next[W-1]!=a[W-1]) under the same load/hold/reset rules as s.
REQ-026 Without RIPPLE_ADDER_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-027 Reset: assert rst mid-run with s=0x9 -> s=0, co=0, out_valid=0 immediately, before the next clk edge.
REQ-028 WIDTH=4, a=0, b=0, c=0, in_valid=1 -> next cycle s=0000, co=0, out_valid=1; sweep a=1,3..13 with b=1 -> s=a+1, co=0.
REQ-029 Carry wrap: a=1, b=15, c=0 -> s=0000, co=1; a=1, b=14 -> s=1111, co=0.
REQ-030 Carry-in: a=5, b=15, c=1 -> s=0101, co=1; a=15, b=15, c=1 -> s=1111, co=1.
REQ-031 Hold: apply result, then in_valid=0 with new operands 7/7 -> s/co unchanged, out_valid=0 from the following cycle.
REQ-032 With RIPPLE_ADDER_OVF_EN: a=7, b=1, c=0 -> s=1000, ovf=1; a=5, b=15, c=1 -> ovf=0.
